// File: rtl/frame_receiver_pkg.sv
// Shared definitions for the frame receiver: FSM state type, default sync
// marker and the CRC-8 (poly 0xD5, MSB first) lookup table with its helpers.
package frame_receiver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [7:0] CRC8_POLY         = 8'hD5;

    // One table entry: eight MSB-first polynomial division steps of idx.
    function automatic logic [7:0] crc8_table_entry(input logic [7:0] idx);
        logic [7:0] c;
        c = idx;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [255:0][7:0] crc8_build_table();
        logic [255:0][7:0] t;
        for (int i = 0; i < 256; i++) begin
            t[i] = crc8_table_entry(8'(i));
        end
        return t;
    endfunction

    // 256-entry table, elaborated once as a constant.
    localparam logic [255:0][7:0] CRC8_TABLE = crc8_build_table();

    // Fold one byte into the running CRC.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        return CRC8_TABLE[crc ^ data];
    endfunction

    // CRC over a 32-bit word, MSB byte first; equivalent to four crc8_step calls.
    function automatic logic [7:0] crc8_word(input logic [31:0] word);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 3; k >= 0; k--) begin
            c = crc8_step(c, word[k*8 +: 8]);
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_receiver_if.sv
// Byte-stream input and frame-status output bundle of the frame receiver.
interface frame_receiver_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [31:0] data_out;
    logic        data_valid;
    logic        crc_err;
    logic        frame_abort;
    logic        busy;

    // Byte source / status consumer side.
    modport master (
        output byte_in, byte_valid,
        input  data_out, data_valid, crc_err, frame_abort, busy
    );

    // Receiver side.
    modport slave (
        input  byte_in, byte_valid,
        output data_out, data_valid, crc_err, frame_abort, busy
    );
endinterface

// File: rtl/frame_receiver_lib.sv
// Library building blocks used by the frame receiver: a shift-in assembly
// register and a clearable up-counter.
module ShiftInRegister #(
    parameter int INWIDTH  = 8,
    parameter int OUTWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                shift_en,
    input  logic [INWIDTH-1:0]  din,
    output logic [OUTWIDTH-1:0] dout
);
    logic [OUTWIDTH-1:0] shift_reg;

    // Shift new data in at the LSB end so the oldest input ends up at the MSBs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[OUTWIDTH-INWIDTH-1:0], din};
        end
    end

    assign dout = shift_reg;
endmodule

module Counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_reg;

    // Clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/frame_receiver.sv
// Frame receiver: hunts for the sync byte, collects 4 payload bytes while
// running CRC-8, then checks the trailing CRC byte. Reports good frames,
// CRC errors and inter-byte timeouts as single-cycle pulses.
module frame_receiver
    import frame_receiver_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    frame_receiver_if.slave  bus
);
    // Counter value at which one more idle cycle means the timeout is hit.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  crc_reg, crc_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [31:0] data_out_reg, data_out_next;
    logic        data_valid_reg, data_valid_next;
    logic        crc_err_reg, crc_err_next;
    logic        frame_abort_reg, frame_abort_next;

    logic        shift_en;
    logic        tmo_clr;
    logic        tmo_inc;
    logic [7:0]  tmo_count;
    logic [31:0] asm_data;
    logic        tmo_expire;

    ShiftInRegister #(.INWIDTH(8), .OUTWIDTH(32)) u_assembly (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .din      (bus.byte_in),
        .dout     (asm_data)
    );

    Counter #(.WIDTH(8)) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmo_clr),
        .inc   (tmo_inc),
        .count (tmo_count)
    );

    assign tmo_expire = (tmo_count == TMO_LAST);

    // State, CRC, byte count and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            crc_reg         <= 8'h00;
            cnt_reg         <= 2'd0;
            data_out_reg    <= 32'h0;
            data_valid_reg  <= 1'b0;
            crc_err_reg     <= 1'b0;
            frame_abort_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            crc_reg         <= crc_next;
            cnt_reg         <= cnt_next;
            data_out_reg    <= data_out_next;
            data_valid_reg  <= data_valid_next;
            crc_err_reg     <= crc_err_next;
            frame_abort_reg <= frame_abort_next;
        end
    end

    // Next-state and datapath control; an accepted byte always beats a timeout.
    always_comb begin
        state_next       = state_reg;
        crc_next         = crc_reg;
        cnt_next         = cnt_reg;
        data_out_next    = data_out_reg;
        data_valid_next  = 1'b0;
        crc_err_next     = 1'b0;
        frame_abort_next = 1'b0;
        shift_en         = 1'b0;
        tmo_clr          = 1'b0;
        tmo_inc          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                tmo_clr = 1'b1;
                if (bus.byte_valid && (bus.byte_in == SYNC_BYTE)) begin
                    crc_next   = 8'h00;
                    cnt_next   = 2'd0;
                    state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (bus.byte_valid) begin
                    tmo_clr  = 1'b1;
                    shift_en = 1'b1;
                    crc_next = crc8_step(crc_reg, bus.byte_in);
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        state_next = ST_CHECK;
                    end
                end else if (tmo_expire) begin
                    tmo_clr          = 1'b1;
                    frame_abort_next = 1'b1;
                    state_next       = ST_IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            ST_CHECK: begin
                if (bus.byte_valid) begin
                    tmo_clr    = 1'b1;
                    state_next = ST_IDLE;
                    if (bus.byte_in == crc_reg) begin
                        data_out_next   = asm_data;
                        data_valid_next = 1'b1;
                    end else begin
                        crc_err_next = 1'b1;
                    end
                end else if (tmo_expire) begin
                    tmo_clr          = 1'b1;
                    frame_abort_next = 1'b1;
                    state_next       = ST_IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.data_out    = data_out_reg;
    assign bus.data_valid  = data_valid_reg;
    assign bus.crc_err     = crc_err_reg;
    assign bus.frame_abort = frame_abort_reg;
    assign bus.busy        = (state_reg != ST_IDLE);

endmodule
